// File: rtl/conv11_pkg.sv
// conv11 shared types and defaults.
// Used by the conv11 input reader, MAC and neighbouring stages.
package conv11_pkg;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    CAPTURE,
    OUT
  } state_t;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_CH_IN      = 4;

  // Product width plus enough headroom for ch full-scale products.
  function automatic int acc_width(input int dw, input int ch);
    return 2 * dw + $clog2(ch);
  endfunction

endpackage

// File: rtl/conv11_input_reader_mac.sv
// conv11 signed multiply-accumulate.
// Ports: clk, rst_n, clr, en, a, b in; acc (registered), sum (acc + a*b) out.
module conv11_mac
  import conv11_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ACC_WIDTH  =
    acc_width(DEF_DATA_WIDTH, DEF_CH_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clr,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] a,
  input  logic signed [DATA_WIDTH-1:0] b,
  output logic signed [ACC_WIDTH-1:0]  acc,
  output logic signed [ACC_WIDTH-1:0]  sum
);

  localparam int PW = 2 * DATA_WIDTH;

  logic signed [PW-1:0]        prod;
  logic signed [ACC_WIDTH-1:0] prod_x;

  assign prod   = a * b;
  assign prod_x = {{(ACC_WIDTH - PW){prod[PW-1]}}, prod};
  assign sum    = acc + prod_x;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc <= '0;
    end else if (clr) begin
      acc <= '0;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/conv11_input_reader.sv
// conv11 input reader: pulls CH_IN samples, MACs with weights, emits a pixel.
// Ports: buffer load/read_en/in_data, weight_addr/data, out valid/ready/data, busy.
module conv11_input_reader
  import conv11_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int CH_IN      = DEF_CH_IN,
  parameter int ACC_WIDTH  = acc_width(DATA_WIDTH, CH_IN),
  localparam int CW        = $clog2(CH_IN)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         inputbuf_load,
  output logic                         inputbuf_read_en,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  output logic [CW-1:0]                weight_addr,
  input  logic signed [DATA_WIDTH-1:0] weight_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [ACC_WIDTH-1:0]  out_data,
  output logic                         busy
);

  localparam logic [CW-1:0] LAST = CW'(CH_IN - 1);

  state_t                      state;
  logic [CW-1:0]               ch;
  logic                        mac_clr;
  logic                        mac_en;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] sum;

  assign mac_en      = (state == CAPTURE);
  assign mac_clr     = (state == OUT) && out_ready;
  assign weight_addr = ch;
  assign busy        = (state != IDLE) || (ch != '0);

  conv11_mac #(
    .DATA_WIDTH(DATA_WIDTH),
    .ACC_WIDTH (ACC_WIDTH)
  ) u_mac (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (mac_clr),
    .en   (mac_en),
    .a    (in_data),
    .b    (weight_data),
    .acc  (acc),
    .sum  (sum)
  );

  // Every channel passes back through IDLE so load is re-sampled
  // only after the buffer has reacted to the previous strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      ch               <= '0;
      inputbuf_read_en <= 1'b0;
      out_valid        <= 1'b0;
      out_data         <= '0;
    end else begin
      inputbuf_read_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (inputbuf_load) begin
            state            <= READ;
            inputbuf_read_en <= 1'b1;
          end
        end
        READ: begin
          state <= CAPTURE;
        end
        CAPTURE: begin
          if (ch == LAST) begin
            state     <= OUT;
            out_valid <= 1'b1;
            out_data  <= sum;
          end else begin
            ch    <= ch + 1'b1;
            state <= IDLE;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            ch        <= '0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_conv11_input_reader.sv
// Self-checking bench for conv11_input_reader.
// Buffer and weight ROM models; pixel sums from a reference model.
module tb_conv11_input_reader;
  import conv11_pkg::*;

  localparam int DW = 8;
  localparam int CH = 4;
  localparam int AW = acc_width(DW, CH);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n;
  logic                 load = 1'b0;
  logic                 read_en;
  logic signed [DW-1:0] in_data = '0;
  logic [1:0]           weight_addr;
  logic signed [DW-1:0] weight_data;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [AW-1:0] out_data;
  logic                 busy;

  logic signed [DW-1:0] w[CH];
  logic                 ready_cmd = 1'b1;
  logic                 rand_mode = 1'b0;
  logic                 rnd_bit = 1'b1;

  assign weight_data = w[weight_addr];
  assign out_ready   = rand_mode ? rnd_bit : ready_cmd;

  conv11_input_reader #(
    .DATA_WIDTH(DW),
    .CH_IN     (CH)
  ) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .inputbuf_load   (load),
    .inputbuf_read_en(read_en),
    .in_data         (in_data),
    .weight_addr     (weight_addr),
    .weight_data     (weight_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready),
    .out_data        (out_data),
    .busy            (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input longint obs,
                     input longint exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference model: samples delivered in order, grouped CH per pixel,
  // pixel = sum of sample[i] * weight[i].
  int                   src_q[$];
  int                   grp[$];
  longint               exp_q[$];
  logic signed [DW-1:0] held = '0;
  int                   gap_max = 0;
  int                   gap_cnt = 0;
  int                   n_fed = 0;
  int                   n_deliv = 0;

  function automatic longint pix_sum(input int g[$]);
    longint s = 0;
    for (int i = 0; i < CH; i++) s += longint'(g[i]) * longint'(w[i]);
    return s;
  endfunction

  task automatic feed(input int v);
    src_q.push_back(v);
    n_fed++;
  endtask

  always @(posedge clk) begin
    if (!rst_n) grp.delete();
    if (read_en) begin
      in_data <= held;
      n_deliv++;
      grp.push_back(int'(held));
      if (grp.size() == CH) begin
        exp_q.push_back(pix_sum(grp));
        grp.delete();
      end
      gap_cnt <= gap_max;
      if (gap_max == 0 && src_q.size() > 0) begin
        held <= DW'(src_q.pop_front());
      end else begin
        load <= 1'b0;
      end
    end else if (!load && src_q.size() > 0) begin
      if (gap_cnt > 0) begin
        gap_cnt <= gap_cnt - 1;
      end else begin
        held <= DW'(src_q.pop_front());
        load <= 1'b1;
      end
    end
  end

  always @(negedge clk) rnd_bit <= 1'($urandom_range(0, 1));

  // Monitor
  int     cyc = 0;
  logic   prev_rd = 1'b0;
  logic   pix_seen = 1'b0;
  int     n_reads = 0;
  int     rd_time_q[$];
  int     rd_addr_q[$];
  longint last_pix = 0;

  always @(negedge clk) begin
    if (rst_n) begin
      if (read_en) begin
        chk("rd_has_load", load, 1);
        chk("rd_not_b2b", prev_rd, 0);
        n_reads++;
        rd_time_q.push_back(cyc);
        rd_addr_q.push_back(int'(weight_addr));
      end
      if (out_valid && !pix_seen) begin
        pix_seen = 1'b1;
        last_pix = longint'(out_data);
        chk("pixel_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) chk("pixel_sum", last_pix, exp_q.pop_front());
      end
    end
    if (!out_valid) pix_seen = 1'b0;
    prev_rd = read_en;
    cyc++;
  end

  task automatic wait_done(input string tag);
    int k;
    logic done = 1'b0;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (src_q.size() == 0 && !load && !busy && !out_valid) begin
        done = 1'b1;
        break;
      end
    end
    chk(tag, done, 1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rd"}, read_en, 0);
    chk({tag, "_ov"}, out_valid, 0);
    chk({tag, "_od"}, longint'(out_data), 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_wa"}, weight_addr, 0);
  endtask

  initial begin
    int t;
    int r0;
    longint d0;
    logic hit;
    for (int i = 0; i < CH; i++) w[i] = 8'sd1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // 1..4 x weights 1: latency, single-cycle valid, read spacing
    rd_time_q.delete();
    for (int i = 1; i <= 4; i++) feed(i);
    hit = 1'b0;
    for (int k = 0; k < 10 && !hit; k++) begin
      @(negedge clk);
      hit = load;
    end
    chk("load_seen", hit, 1);
    t = 0;
    while (!out_valid && t < 50) begin
      @(negedge clk);
      t++;
    end
    chk("latency", t, 12);
    chk("out_10", longint'(out_data), 10);
    @(negedge clk);
    chk("valid_one_cycle", out_valid, 0);
    chk("n_reads_4", rd_time_q.size(), 4);
    for (int i = 1; i < rd_time_q.size(); i++)
      chk("rd_spacing", rd_time_q[i] - rd_time_q[i-1], 3);
    wait_done("done_basic");

    // Signed extremes
    for (int i = 0; i < CH; i++) w[i] = 8'sd127;
    for (int i = 0; i < 4; i++) feed(-128);
    wait_done("done_neg");
    chk("neg_extreme", last_pix, -65024);
    for (int i = 0; i < 4; i++) feed(127);
    wait_done("done_pos");
    chk("pos_extreme", last_pix, 64516);

    // Backpressure with a pending sample
    w[0] = 8'sd1; w[1] = -8'sd2; w[2] = 8'sd3; w[3] = -8'sd4;
    ready_cmd = 1'b0;
    for (int i = 5; i <= 9; i++) feed(i);
    t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    chk("bp_valid", out_valid, 1);
    r0 = n_reads;
    d0 = longint'(out_data);
    chk("bp_data", d0, 5 - 12 + 21 - 32);
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid_hold", out_valid, 1);
      chk("bp_data_hold", longint'(out_data), d0);
      chk("bp_load_pend", load, 1);
    end
    chk("bp_no_reads", n_reads - r0, 0);
    ready_cmd = 1'b1;
    @(negedge clk);
    chk("bp_rd_gap", read_en, 0);
    chk("bp_released", out_valid, 0);
    @(negedge clk);
    chk("bp_rd_after2", read_en, 1);
    for (int i = 0; i < 3; i++) feed(1);
    wait_done("done_bp");
    chk("bp_next_pixel", last_pix, 9 - 2 + 3 - 4);

    // Continuous load: weight_addr sequence at each strobe
    for (int i = 0; i < CH; i++) w[i] = 8'sd1;
    rd_addr_q.delete();
    rd_time_q.delete();
    for (int i = 0; i < 8; i++) feed($urandom_range(0, 255) - 128);
    wait_done("done_cont");
    for (int i = 0; i < 5; i++) chk("wa_step", rd_addr_q[i], i % CH);
    for (int i = 1; i < 4; i++)
      chk("cont_spacing", rd_time_q[i] - rd_time_q[i-1], 3);

    // Reset after two channels
    feed(10); feed(20); feed(30); feed(40); feed(50); feed(60);
    hit = 1'b0;
    for (int k = 0; k < 100 && !hit; k++) begin
      @(negedge clk);
      hit = (grp.size() == 2);
    end
    chk("two_ch_seen", hit, 1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk_reset_vals("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    wait_done("done_rst");
    chk("post_rst_pixel", last_pix, 180);

    // Randomized: weights, samples, refill gaps, downstream ready
    rand_mode = 1'b1;
    for (int b = 0; b < 6; b++) begin
      for (int i = 0; i < CH; i++)
        w[i] = DW'($urandom_range(0, 255));
      gap_max = $urandom_range(0, 3);
      for (int p = 0; p < 5 * CH; p++)
        feed($urandom_range(0, 255) - 128);
      wait_done("done_rand");
    end
    rand_mode = 1'b0;
    chk("all_delivered", n_deliv, n_fed);
    chk("exp_drained", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
